// File: rtl/eth_arb_pkg.sv
// rtl/eth_arb_pkg.sv - shared types and constants for the Ethernet TX frame arbiter
// Purpose: arbiter FSM state encoding and the default frame-length watchdog limit.
// Ports: none (package).
package eth_arb_pkg;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_fwd   = 2'd1,
    e_drain = 2'd2
  } eth_arb_state_e;

  // 1518-byte maximum frame carried on a 64-bit bus
  localparam int eth_max_frame_beats_gp = 190;

endpackage

// File: rtl/eth_rr_arb.sv
// rtl/eth_rr_arb.sv - combinational rotate-priority one-hot picker
// Purpose: returns the first requester at or after rr_ptr_i, wrapping from num_src_p-1 to 0.
// Ports:
//   req_i       in   [num_src_p]        request vector
//   rr_ptr_i    in   [clog2(num_src_p)] index holding highest priority
//   grant_o     out  [num_src_p]        one-hot winner, 0 when no request
//   grant_id_o  out  [clog2(num_src_p)] index of the winner
//   any_o       out  1                  at least one request present
module eth_rr_arb
  import eth_arb_pkg::*;
#(
  parameter int num_src_p = 4
) (
  input  logic [num_src_p-1:0]         req_i,
  input  logic [$clog2(num_src_p)-1:0] rr_ptr_i,
  output logic [num_src_p-1:0]         grant_o,
  output logic [$clog2(num_src_p)-1:0] grant_id_o,
  output logic                         any_o
);

  localparam int id_w_lp = $clog2(num_src_p);
  localparam logic [id_w_lp:0] num_w_lp = (id_w_lp+1)'(num_src_p);

  // One extra bit so ptr + offset (< 2*num_src_p) never overflows before the wrap
  logic [id_w_lp:0]   idx_ext;
  logic [id_w_lp-1:0] idx;

  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    any_o      = 1'b0;
    idx_ext    = '0;
    idx        = '0;
    for (int i = 0; i < num_src_p; i++) begin
      idx_ext = {1'b0, rr_ptr_i} + (id_w_lp+1)'(i);
      if (idx_ext >= num_w_lp) begin
        idx_ext = idx_ext - num_w_lp;
      end
      idx = idx_ext[id_w_lp-1:0];
      if (!any_o && req_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_id_o   = idx;
      end
    end
  end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// rtl/eth_tx_frame_arbiter.sv - frame-granular round-robin arbiter onto one TX AXIS port
// Purpose: shares the MAC TX stream among num_src_p sources; a grant lasts from a source's
//   first beat to its tlast handshake, so frames never interleave. One idle cycle per frame.
// Optional feature: define ETH_TX_ARB_WATCHDOG_EN to cut frames longer than max_frame_beats_p
//   (last forwarded beat gets tlast=1, tuser=1; the rest of the source frame is drained).
// Ports:
//   clk_i, reset_n_i                    clock, async active-low reset
//   src_tdata_i/tkeep_i/tvalid_i/
//   tlast_i/tuser_i, src_tready_o       per-source AXIS slaves, flattened per source
//   tx_axis_*                           AXIS master towards the MAC FIFO
//   grant_o                             one-hot current owner, 0 when idle
//   busy_o                              arbiter not idle
module eth_tx_frame_arbiter
  import eth_arb_pkg::*;
#(
  parameter int num_src_p         = 4,
  parameter int axis_data_width_p = 64,
  parameter int max_frame_beats_p = eth_max_frame_beats_gp
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,
  input  logic [num_src_p*axis_data_width_p-1:0]   src_tdata_i,
  input  logic [num_src_p*axis_data_width_p/8-1:0] src_tkeep_i,
  input  logic [num_src_p-1:0]                     src_tvalid_i,
  output logic [num_src_p-1:0]                     src_tready_o,
  input  logic [num_src_p-1:0]                     src_tlast_i,
  input  logic [num_src_p-1:0]                     src_tuser_i,
  output logic [axis_data_width_p-1:0]             tx_axis_tdata_o,
  output logic [axis_data_width_p/8-1:0]           tx_axis_tkeep_o,
  output logic                                     tx_axis_tvalid_o,
  input  logic                                     tx_axis_tready_i,
  output logic                                     tx_axis_tlast_o,
  output logic                                     tx_axis_tuser_o,
  output logic [num_src_p-1:0]                     grant_o,
  output logic                                     busy_o
);

  localparam int keep_w_lp = axis_data_width_p/8;
  localparam int id_w_lp   = $clog2(num_src_p);
  localparam logic [id_w_lp-1:0] last_id_lp = id_w_lp'(num_src_p-1);

  eth_arb_state_e     state_q;
  logic [num_src_p-1:0] grant_q;
  logic [id_w_lp-1:0] gid_q;
  logic [id_w_lp-1:0] rr_q;

  logic [num_src_p-1:0] arb_grant;
  logic [id_w_lp-1:0]   arb_id;
  logic                 arb_any;

  eth_rr_arb #(.num_src_p(num_src_p)) u_rr_arb (
    .req_i      (src_tvalid_i),
    .rr_ptr_i   (rr_q),
    .grant_o    (arb_grant),
    .grant_id_o (arb_id),
    .any_o      (arb_any)
  );

  logic [axis_data_width_p-1:0] mux_data;
  logic [keep_w_lp-1:0]         mux_keep;
  logic                         mux_valid;
  logic                         mux_last;
  logic                         mux_user;

  // grant_q is one-hot or zero, so a priority-free select is exact
  always_comb begin
    mux_data  = '0;
    mux_keep  = '0;
    mux_valid = 1'b0;
    mux_last  = 1'b0;
    mux_user  = 1'b0;
    for (int i = 0; i < num_src_p; i++) begin
      if (grant_q[i]) begin
        mux_data  = src_tdata_i[i*axis_data_width_p +: axis_data_width_p];
        mux_keep  = src_tkeep_i[i*keep_w_lp +: keep_w_lp];
        mux_valid = src_tvalid_i[i];
        mux_last  = src_tlast_i[i];
        mux_user  = src_tuser_i[i];
      end
    end
  end

  logic               in_fwd;
  logic               in_drain;
  logic               force_end;
  logic               beat_acc;
  logic [id_w_lp-1:0] rr_next;

  assign in_fwd   = (state_q == e_fwd);
  assign beat_acc = in_fwd & mux_valid & tx_axis_tready_i;
  assign rr_next  = (gid_q == last_id_lp) ? '0 : gid_q + 1'b1;

`ifdef ETH_TX_ARB_WATCHDOG_EN
  localparam int cnt_w_lp = $clog2(max_frame_beats_p+1);
  localparam logic [cnt_w_lp-1:0] limit_m1_lp = cnt_w_lp'(max_frame_beats_p-1);

  // Counts beats already accepted in the current frame
  logic [cnt_w_lp-1:0] beat_cnt_q;

  // The beat on the bus is beat number max_frame_beats_p and is not a real end of frame
  assign force_end = (beat_cnt_q == limit_m1_lp) & ~mux_last;
  assign in_drain  = (state_q == e_drain);
`else
  assign force_end = 1'b0;
  assign in_drain  = 1'b0;
`endif

  assign tx_axis_tvalid_o = in_fwd & mux_valid;
  assign tx_axis_tdata_o  = in_fwd ? mux_data : '0;
  assign tx_axis_tkeep_o  = in_fwd ? mux_keep : '0;
  assign tx_axis_tlast_o  = in_fwd & (mux_last | force_end);
  assign tx_axis_tuser_o  = in_fwd & (mux_user | force_end);
  // Draining sinks the owner's beats regardless of downstream backpressure
  assign src_tready_o     = grant_q & ({num_src_p{in_fwd & tx_axis_tready_i}} | {num_src_p{in_drain}});
  assign grant_o          = grant_q;
  assign busy_o           = (state_q != e_idle);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= e_idle;
      grant_q    <= '0;
      gid_q      <= '0;
      rr_q       <= '0;
`ifdef ETH_TX_ARB_WATCHDOG_EN
      beat_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        e_idle: begin
          if (arb_any) begin
            state_q    <= e_fwd;
            grant_q    <= arb_grant;
            gid_q      <= arb_id;
`ifdef ETH_TX_ARB_WATCHDOG_EN
            beat_cnt_q <= '0;
`endif
          end
        end
        e_fwd: begin
          if (beat_acc) begin
`ifdef ETH_TX_ARB_WATCHDOG_EN
            beat_cnt_q <= beat_cnt_q + 1'b1;
`endif
            if (mux_last) begin
              state_q <= e_idle;
              grant_q <= '0;
              rr_q    <= rr_next;
            end else if (force_end) begin
              state_q <= e_drain;
            end
          end
        end
`ifdef ETH_TX_ARB_WATCHDOG_EN
        e_drain: begin
          if (mux_valid && mux_last) begin
            state_q <= e_idle;
            grant_q <= '0;
            rr_q    <= rr_next;
          end
        end
`endif
        default: begin
          state_q <= e_idle;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// tb/tb_eth_tx_frame_arbiter.sv - self-checking bench for eth_tx_frame_arbiter
module tb_eth_tx_frame_arbiter;

  localparam int N    = 4;
  localparam int W    = 64;
  localparam int KW   = W/8;
  localparam int MAXB = 4;
`ifdef ETH_TX_ARB_WATCHDOG_EN
  localparam bit wd_en = 1'b1;
`else
  localparam bit wd_en = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
    logic [N-1:0]  grant;
  } beat_t;

  logic            clk;
  logic            reset_n;
  logic [N*W-1:0]  src_tdata;
  logic [N*KW-1:0] src_tkeep;
  logic [N-1:0]    src_tvalid;
  logic [N-1:0]    src_tready;
  logic [N-1:0]    src_tlast;
  logic [N-1:0]    src_tuser;
  logic [W-1:0]    tx_tdata;
  logic [KW-1:0]   tx_tkeep;
  logic            tx_tvalid;
  logic            tx_tready;
  logic            tx_tlast;
  logic            tx_tuser;
  logic [N-1:0]    grant;
  logic            busy;

  eth_tx_frame_arbiter #(
    .num_src_p(N), .axis_data_width_p(W), .max_frame_beats_p(MAXB)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .src_tdata_i(src_tdata), .src_tkeep_i(src_tkeep), .src_tvalid_i(src_tvalid),
    .src_tready_o(src_tready), .src_tlast_i(src_tlast), .src_tuser_i(src_tuser),
    .tx_axis_tdata_o(tx_tdata), .tx_axis_tkeep_o(tx_tkeep), .tx_axis_tvalid_o(tx_tvalid),
    .tx_axis_tready_i(tx_tready), .tx_axis_tlast_o(tx_tlast), .tx_axis_tuser_o(tx_tuser),
    .grant_o(grant), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    chk;
  int    err;
  int    rr_m;
  beat_t src_q[N][$];
  beat_t mq[N][$];
  beat_t exp_q[$];
  beat_t obs_q[$];
  bit    started[N];

  task automatic clear_inputs();
    src_tdata  = '0;
    src_tkeep  = '0;
    src_tvalid = '0;
    src_tlast  = '0;
    src_tuser  = '0;
  endtask

  task automatic load_frame(input int s, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data  = {$urandom, $urandom};
      b.keep  = KW'($urandom);
      b.last  = (i == len-1);
      b.user  = 1'($urandom);
      b.grant = '0;
      src_q[s].push_back(b);
    end
  endtask

  // Reference: every queued source is a requester; pick round-robin from the model pointer,
  // move the whole frame, cut it at MAXB beats when the watchdog is built in.
  task automatic build_expected();
    int    s;
    int    n;
    bit    drop;
    bit    src_last;
    beat_t b;
    exp_q.delete();
    for (int i = 0; i < N; i++) mq[i] = src_q[i];
    forever begin
      s = -1;
      for (int k = 0; k < N; k++)
        if (s < 0 && mq[(rr_m+k)%N].size() > 0) s = (rr_m+k)%N;
      if (s < 0) break;
      n = 0;
      drop = 1'b0;
      do begin
        b = mq[s].pop_front();
        n++;
        src_last = b.last;
        b.grant = N'(1) << s;
        if (!drop) begin
          if (wd_en && n == MAXB && !src_last) begin
            b.last = 1'b1;
            b.user = 1'b1;
            drop   = 1'b1;
          end
          exp_q.push_back(b);
        end
      end while (!src_last);
      rr_m = (s+1) % N;
    end
  endtask

  // mode 0: sink always ready; 1: sink ready 1010...; 2: random sink and mid-frame source gaps
  task automatic run_traffic(input int mode, output int cycles);
    beat_t b;
    beat_t ob;
    bit    gap;
    int    pending;
    build_expected();
    obs_q.delete();
    cycles = 0;
    for (int s = 0; s < N; s++) started[s] = 1'b0;
    pending = 0;
    for (int s = 0; s < N; s++) pending += src_q[s].size();
    while (pending > 0 && cycles < 2000) begin
      @(negedge clk);
      for (int s = 0; s < N; s++) begin
        gap = (mode == 2) && started[s] && ($urandom_range(3) == 0);
        if (src_q[s].size() > 0 && !gap) begin
          b = src_q[s][0];
          src_tvalid[s]          = 1'b1;
          src_tdata[s*W +: W]    = b.data;
          src_tkeep[s*KW +: KW]  = b.keep;
          src_tlast[s]           = b.last;
          src_tuser[s]           = b.user;
        end else begin
          src_tvalid[s]          = 1'b0;
          src_tdata[s*W +: W]    = '0;
          src_tkeep[s*KW +: KW]  = '0;
          src_tlast[s]           = 1'b0;
          src_tuser[s]           = 1'b0;
        end
      end
      case (mode)
        0:       tx_tready = 1'b1;
        1:       tx_tready = (cycles % 2 == 0);
        default: tx_tready = ($urandom_range(3) != 0);
      endcase
      #3;
      if (tx_tvalid && tx_tready) begin
        ob.data  = tx_tdata;
        ob.keep  = tx_tkeep;
        ob.last  = tx_tlast;
        ob.user  = tx_tuser;
        ob.grant = grant;
        obs_q.push_back(ob);
      end
      for (int s = 0; s < N; s++) begin
        if (src_tvalid[s] && src_tready[s]) begin
          b = src_q[s].pop_front();
          started[s] = !b.last;
        end
      end
      cycles++;
      pending = 0;
      for (int s = 0; s < N; s++) pending += src_q[s].size();
    end
    chk++;
    if (pending > 0) begin
      err++;
      $display("FAIL run_timeout pending beats %0d after %0d cycles, required 0", pending, cycles);
      for (int s = 0; s < N; s++) src_q[s].delete();
    end
    @(negedge clk);
    clear_inputs();
    tx_tready = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    src_tvalid = '1;
    tx_tready  = 1'b1;
    reset_n    = 1'b0;
    repeat (2) @(negedge clk);
    chk++; if (src_tready !== '0) begin err++; $display("FAIL reset_tready got %b required 0000", src_tready); end
    chk++; if (tx_tvalid !== 1'b0) begin err++; $display("FAIL reset_tvalid got %b required 0", tx_tvalid); end
    chk++; if (grant !== '0) begin err++; $display("FAIL reset_grant got %b required 0000", grant); end
    chk++; if ({busy, tx_tlast, tx_tuser} !== 3'b000) begin err++; $display("FAIL reset_flags got %b required 000", {busy, tx_tlast, tx_tuser}); end
    reset_n = 1'b1;
    @(negedge clk);
    chk++; if (grant !== 4'b0001) begin err++; $display("FAIL reset_first_grant got %b required 0001", grant); end
    #2 reset_n = 1'b0;
    #1;
    chk++; if ({grant, src_tready, busy} !== 9'b0) begin err++; $display("FAIL reset_async got grant %b tready %b busy %b required all 0", grant, src_tready, busy); end
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b1;
    rr_m = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    rr_m = 0;
  endtask

  task automatic test_two_src();
    int cyc;
    load_frame(0, 3);
    load_frame(2, 3);
    run_traffic(0, cyc);
    chk++; if (cyc !== 8) begin err++; $display("FAIL two_src_cycles got %0d required 8", cyc); end
    chk++; if (obs_q.size() !== exp_q.size()) begin err++; $display("FAIL two_src_count got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk++; if (obs_q[i] !== exp_q[i]) begin err++; $display("FAIL two_src_beat%0d got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++) load_frame(s, 1);
    run_traffic(0, cyc);
    chk++; if (cyc !== 16) begin err++; $display("FAIL b2b_cycles got %0d required 16", cyc); end
    chk++; if (obs_q.size() !== exp_q.size()) begin err++; $display("FAIL b2b_count got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk++; if (obs_q[i] !== exp_q[i]) begin err++; $display("FAIL b2b_beat%0d got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    load_frame(1, 6);
    run_traffic(1, cyc);
    chk++; if (cyc !== 13) begin err++; $display("FAIL bp_cycles got %0d required 13", cyc); end
    chk++; if (obs_q.size() !== exp_q.size()) begin err++; $display("FAIL bp_count got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk++; if (obs_q[i] !== exp_q[i]) begin err++; $display("FAIL bp_beat%0d got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_wrap();
    int cyc;
    do_reset();
    load_frame(2, 2);
    run_traffic(0, cyc);
    load_frame(3, 3);
    load_frame(1, 2);
    run_traffic(0, cyc);
    chk++; if (obs_q.size() !== exp_q.size()) begin err++; $display("FAIL wrap_count got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk++; if (obs_q[i] !== exp_q[i]) begin err++; $display("FAIL wrap_beat%0d got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_watchdog();
    int cyc;
    load_frame(0, 6);
    run_traffic(0, cyc);
    chk++; if (cyc !== 7) begin err++; $display("FAIL wd_cycles got %0d required 7", cyc); end
    chk++; if (busy !== 1'b0) begin err++; $display("FAIL wd_idle_after got busy %b required 0", busy); end
    chk++; if (obs_q.size() !== exp_q.size()) begin err++; $display("FAIL wd_count got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk++; if (obs_q[i] !== exp_q[i]) begin err++; $display("FAIL wd_beat%0d got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int cyc;
    for (int r = 0; r < 15; r++) begin
      for (int s = 0; s < N; s++)
        for (int f = $urandom_range(0, 2); f > 0; f--) load_frame(s, $urandom_range(1, 6));
      run_traffic(2, cyc);
      chk++; if (obs_q.size() !== exp_q.size()) begin err++; $display("FAIL rand%0d_count got %0d required %0d", r, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        chk++; if (obs_q[i] !== exp_q[i]) begin err++; $display("FAIL rand%0d_beat%0d got %h required %h", r, i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    chk       = 0;
    err       = 0;
    rr_m      = 0;
    reset_n   = 1'b0;
    tx_tready = 1'b1;
    clear_inputs();
    test_reset();
    test_two_src();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_watchdog();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
